// File: rtl/sync_sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared types and helpers for the sync_sram storage block.
//   sram_state_t : controller state (idle / sequential clear)
//   BYTE_W       : width of one write-enable lane
//   be_width()   : number of byte lanes for a given word width
// ---------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic {
        SRAM_IDLE  = 1'b0,
        SRAM_CLEAR = 1'b1
    } sram_state_t;

    localparam int BYTE_W = 8;

    function automatic int be_width(input int data_width);
        return data_width / BYTE_W;
    endfunction

endpackage

// File: rtl/sync_sram_if.sv
// ---------------------------------------------------------------------------
// sync_sram_if
// Request/response bundle of the sync_sram block.
//   req_valid/req_ready : request handshake (transfer when both high)
//   req_we              : 1 = write, 0 = read
//   req_be              : byte enables for writes
//   adr                 : word address
//   wdata               : write data
//   rsp_valid           : one-cycle pulse per accepted read
//   rdata               : read data (holds while rsp_valid=0)
//   rsp_err             : read address was out of range
// master drives requests; slave (the memory) drives ready and responses.
// ---------------------------------------------------------------------------
interface sync_sram_if
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) ();

    localparam int BE_W = be_width(DATA_WIDTH);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [BE_W-1:0]       req_be;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_be, adr, wdata,
        input  req_ready, rsp_valid, rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, adr, wdata,
        output req_ready, rsp_valid, rdata, rsp_err
    );

endinterface

// File: rtl/sync_sram_array.sv
// ---------------------------------------------------------------------------
// sram_array
// Raw storage: byte-masked synchronous write, registered synchronous read
// (one cycle). The caller guarantees addr < DEPTH whenever en is high.
//   clk   : rising-edge clock
//   en    : access strobe
//   we    : 1 = write enabled lanes, 0 = read into rdata
//   be    : byte-lane enables
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, changes only on a read access
// ---------------------------------------------------------------------------
module sram_array
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter     INIT_FILE  = ""
) (
    input  logic                              clk,
    input  logic                              en,
    input  logic                              we,
    input  logic [be_width(DATA_WIDTH)-1:0]   be,
    input  logic [ADDR_WIDTH-1:0]             addr,
    input  logic [DATA_WIDTH-1:0]             wdata,
    output logic [DATA_WIDTH-1:0]             rdata
);

    localparam int BE_W = be_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sync_sram.sv
// ---------------------------------------------------------------------------
// sync_sram
// Single-port synchronous SRAM with valid/ready requests, byte-lane write
// masking, read latency of 1 or 2 cycles, out-of-range flagging and a
// sequential clear engine (one word per cycle).
//   clk        : rising-edge clock
//   reset_n    : synchronous active-low reset (memory contents untouched)
//   bus        : sync_sram_if slave (request handshake and read response)
//   clear_req  : start a clear when idle; wins over a same-cycle request
//   clear_busy : clear in progress (requests are stalled)
// ---------------------------------------------------------------------------
module sync_sram
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 256,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter     INIT_FILE      = ""
) (
    input  logic         clk,
    input  logic         reset_n,
    sync_sram_if.slave   bus,
    input  logic         clear_req,
    output logic         clear_busy
);

    localparam int BE_W = be_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADR  = ADDR_WIDTH'(DEPTH - 1);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sync_sram: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_W != 0 || DATA_WIDTH <= 0) begin : g_bad_width
        $error("sync_sram: DATA_WIDTH must be a positive multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
        $error("sync_sram: DEPTH must lie in 1..2**ADDR_WIDTH");
    end

    sram_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic                  fire;
    logic                  in_range;
    logic                  arr_en, arr_we;
    logic [BE_W-1:0]       arr_be;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata;

    logic                  vld_p1, err_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [DATA_WIDTH-1:0] rdata_p2;

    assign bus.req_ready = (state_q == SRAM_IDLE) && !clear_req;
    assign clear_busy    = (state_q == SRAM_CLEAR);
    assign fire          = bus.req_valid && bus.req_ready;
    assign in_range      = {1'b0, bus.adr} < DEPTH_EXT;

    // Clear controller
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? SRAM_CLEAR : SRAM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SRAM_IDLE: begin
                if (clear_req) begin
                    state_d = SRAM_CLEAR;
                    cnt_d   = '0;
                end
            end
            SRAM_CLEAR: begin
                if (cnt_q == LAST_ADR) begin
                    state_d = SRAM_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SRAM_IDLE;
        endcase
    end

    // Port mux: the clear engine owns the array while busy; otherwise only
    // in-range requests touch it, so out-of-range writes vanish.
    always_comb begin
        arr_en    = fire && in_range;
        arr_we    = bus.req_we;
        arr_be    = bus.req_be;
        arr_addr  = bus.adr;
        arr_wdata = bus.wdata;
        if (state_q == SRAM_CLEAR) begin
            arr_en    = 1'b1;
            arr_we    = 1'b1;
            arr_be    = '1;
            arr_addr  = cnt_q;
            arr_wdata = '0;
        end
    end

    sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .be    (arr_be),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // Stage p1: array output is valid; tag it with the accepted read
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else begin
            vld_p1 <= fire && !bus.req_we;
            err_p1 <= fire && !bus.req_we && !in_range;
        end
    end

    assign data_p1 = err_p1 ? '0 : arr_rdata;

    // Stage p2: last delivered word; doubles as the hold register for the
    // single-cycle latency output since the array register is not reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_p2 <= '0;
        end else if (vld_p1) begin
            rdata_p2 <= data_p1;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic vld_p2, err_p2;
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                vld_p2 <= 1'b0;
                err_p2 <= 1'b0;
            end else begin
                vld_p2 <= vld_p1;
                err_p2 <= err_p1;
            end
        end
        assign bus.rsp_valid = vld_p2;
        assign bus.rsp_err   = err_p2;
        assign bus.rdata     = rdata_p2;
    end else begin : g_lat1
        assign bus.rsp_valid = vld_p1;
        assign bus.rsp_err   = err_p1;
        assign bus.rdata     = vld_p1 ? data_p1 : rdata_p2;
    end

endmodule

// File: tb/tb_sync_sram.sv
// ---------------------------------------------------------------------------
// tb_sync_sram
// Directed bench for sync_sram. Two instances share the request stimulus:
//   dut_a : DEPTH=256, READ_LATENCY=1, CLEAR_ON_RESET=1
//   dut_b : DEPTH=200, READ_LATENCY=2, CLEAR_ON_RESET=0
// Each instance has its own clear_req.
// ---------------------------------------------------------------------------
module tb_sync_sram;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid, we;
    logic [1:0]  be;
    logic [7:0]  adr;
    logic [15:0] wdata;
    logic        clear_req_a, clear_req_b;
    logic        busy_a, busy_b;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    sync_sram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) a_if ();
    sync_sram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) b_if ();

    assign a_if.req_valid = valid;
    assign a_if.req_we    = we;
    assign a_if.req_be    = be;
    assign a_if.adr       = adr;
    assign a_if.wdata     = wdata;
    assign b_if.req_valid = valid;
    assign b_if.req_we    = we;
    assign b_if.req_be    = be;
    assign b_if.adr       = adr;
    assign b_if.wdata     = wdata;

    sync_sram #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(256),
        .READ_LATENCY(1), .CLEAR_ON_RESET(1), .INIT_FILE("")
    ) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (a_if),
        .clear_req  (clear_req_a),
        .clear_busy (busy_a)
    );

    sync_sram #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(200),
        .READ_LATENCY(2), .CLEAR_ON_RESET(0), .INIT_FILE("")
    ) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (b_if),
        .clear_req  (clear_req_b),
        .clear_busy (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
        valid = 1'b1; we = 1'b1; adr = a; wdata = d; be = b;
        step();
        valid = 1'b0; we = 1'b0;
    endtask

    // Issues one read to both instances; returns what each delivered at its latency.
    task automatic rd(input logic [7:0] a,
                      output logic [15:0] da, output logic ea,
                      output logic [15:0] db, output logic eb);
        valid = 1'b1; we = 1'b0; adr = a;
        step();
        valid = 1'b0;
        check("a_rsp_valid_lat1", a_if.rsp_valid, 1);
        check("b_rsp_valid_not_yet", b_if.rsp_valid, 0);
        da = a_if.rdata;
        ea = a_if.rsp_err;
        step();
        check("b_rsp_valid_lat2", b_if.rsp_valid, 1);
        check("a_rsp_valid_pulse", a_if.rsp_valid, 0);
        db = b_if.rdata;
        eb = b_if.rsp_err;
    endtask

    // Counts samples with dut_a busy; flags any ready or response while busy.
    task automatic count_busy(output int n, output int bad);
        n = 0;
        bad = 0;
        while (busy_a && n < 2000) begin
            if (a_if.req_ready !== 1'b0 || a_if.rsp_valid !== 1'b0) bad++;
            step();
            n++;
        end
    endtask

    initial begin
        logic [15:0] da, db;
        logic        ea, eb;
        int          n, bad;

        reset_n = 1'b0; valid = 1'b0; we = 1'b0; be = 2'b00;
        adr = 8'h00; wdata = 16'h0000; clear_req_a = 1'b0; clear_req_b = 1'b0;
        step();
        step();

        // Reset state
        check("rst_a_busy", busy_a, 1);
        check("rst_a_ready", a_if.req_ready, 0);
        check("rst_a_rsp_valid", a_if.rsp_valid, 0);
        check("rst_a_rdata", a_if.rdata, 0);
        check("rst_a_rsp_err", a_if.rsp_err, 0);
        check("rst_b_busy", busy_b, 0);
        check("rst_b_ready", b_if.req_ready, 1);
        check("rst_b_rsp_valid", b_if.rsp_valid, 0);
        check("rst_b_rdata", b_if.rdata, 0);

        // 1: clear after reset lasts DEPTH cycles, memory reads zero
        reset_n = 1'b1;
        count_busy(n, bad);
        check("clear_len_after_reset", n, 256);
        check("clear_ready_low", bad, 0);
        check("a_ready_after_clear", a_if.req_ready, 1);
        rd(8'h00, da, ea, db, eb);
        check("a_rd_00", da, 16'h0000);
        rd(8'h7F, da, ea, db, eb);
        check("a_rd_7f", da, 16'h0000);
        rd(8'hFF, da, ea, db, eb);
        check("a_rd_ff", da, 16'h0000);
        check("a_rd_ff_err", ea, 0);

        // 2: byte-masked overwrite, and be=0 is a no-op
        wr(8'h10, 16'hBEEF, 2'b11);
        wr(8'h10, 16'h1234, 2'b01);
        rd(8'h10, da, ea, db, eb);
        check("a_rd_mask", da, 16'hBE34);
        check("b_rd_mask", db, 16'hBE34);
        wr(8'h10, 16'hFFFF, 2'b00);
        rd(8'h10, da, ea, db, eb);
        check("a_rd_be0", da, 16'hBE34);
        check("b_rd_be0", db, 16'hBE34);

        // 3: DEPTH boundary on dut_b (200), in-range on dut_a
        wr(8'hC8, 16'hAAAA, 2'b11);
        rd(8'hC8, da, ea, db, eb);
        check("a_rd_c8", da, 16'hAAAA);
        check("a_rd_c8_err", ea, 0);
        check("b_rd_c8", db, 16'h0000);
        check("b_rd_c8_err", eb, 1);
        step();
        check("b_hold_rdata", b_if.rdata, 16'h0000);
        check("b_hold_err", b_if.rsp_err, 0);
        check("b_hold_valid", b_if.rsp_valid, 0);
        check("a_hold_rdata", a_if.rdata, 16'hAAAA);
        rd(8'hC7, da, ea, db, eb);
        check("b_rd_c7_err", eb, 0);
        check("a_rd_c7", da, 16'h0000);

        // 4: back-to-back reads, in order, one per cycle
        for (int i = 1; i <= 4; i++) wr(8'(i), 16'(i * 'h11), 2'b11);
        valid = 1'b1; we = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            adr = 8'(i);
            step();
            check("a_b2b_valid", a_if.rsp_valid, 1);
            check("a_b2b_data", a_if.rdata, 32'(i * 'h11));
            if (i > 1) begin
                check("b_b2b_valid", b_if.rsp_valid, 1);
                check("b_b2b_data", b_if.rdata, 32'((i - 1) * 'h11));
            end
        end
        valid = 1'b0;
        step();
        check("a_b2b_end", a_if.rsp_valid, 0);
        check("b_b2b_last_valid", b_if.rsp_valid, 1);
        check("b_b2b_last_data", b_if.rdata, 16'h0044);
        step();

        // 5: clear wins over a same-cycle write
        clear_req_a = 1'b1;
        valid = 1'b1; we = 1'b1; adr = 8'h05; wdata = 16'h5555; be = 2'b11;
        #1;
        check("a_ready_vs_clear", a_if.req_ready, 0);
        check("b_ready_no_clear", b_if.req_ready, 1);
        step();
        clear_req_a = 1'b0; valid = 1'b0; we = 1'b0;
        check("a_busy_rise", busy_a, 1);
        count_busy(n, bad);
        check("clear_len_req", n, 256);
        check("clear_req_ready_low", bad, 0);
        rd(8'h05, da, ea, db, eb);
        check("a_rd_05_cleared", da, 16'h0000);
        check("b_rd_05_written", db, 16'h5555);

        // 6: reset mid-clear restarts the clear from address 0
        clear_req_a = 1'b1;
        step();
        clear_req_a = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy_a !== 1'b1 || a_if.rsp_valid !== 1'b0) bad++;
            step();
        end
        check("clear_first_100", bad, 0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("a_busy_after_mid_reset", busy_a, 1);
        count_busy(n, bad);
        check("clear_len_restart", n, 256);
        check("clear_restart_no_rsp", bad, 0);
        rd(8'h10, da, ea, db, eb);
        check("a_rd_10_after_restart", da, 16'h0000);
        check("b_rd_10_kept", db, 16'hBE34);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
